// File: rtl/conv_pkg.sv
// Shared conv-layer definitions: output geometry, window width and the
// frame-sequencing state encoding used by the conv-layer controllers.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_state_e;

  // One output dimension of a stride-1 convolution.
  function automatic int out_dim(input int img, input int pad, input int k);
    return img + 2 * pad - k + 1;
  endfunction

  // Number of windows (output pixels) in one frame.
  function automatic int out_total(input int w, input int h, input int pad, input int k);
    return out_dim(w, pad, k) * out_dim(h, pad, k);
  endfunction

  // Bits in one packed KxK window across all channels.
  function automatic int win_width(input int dw, input int k, input int ch);
    return dw * k * k * ch;
  endfunction

endpackage

// File: rtl/window_dispatch_if.sv
// Window stream in from the line buffer and shared window bus out to the PEs.
// slave = dispatcher view, master = line buffer / PE array view.
interface window_dispatch_if #(
  parameter int WIN_W  = 216,
  parameter int NUM_PE = 2
);
  logic              win_valid;
  logic [WIN_W-1:0]  win_data;
  logic              win_ready;
  logic [NUM_PE-1:0] pe_ready;
  logic [NUM_PE-1:0] pe_valid;
  logic [WIN_W-1:0]  pe_data;
  logic [7:0]        pe_row;
  logic [7:0]        pe_col;

  modport slave (
    input  win_valid, win_data, pe_ready,
    output win_ready, pe_valid, pe_data, pe_row, pe_col
  );

  modport master (
    output win_valid, win_data, pe_ready,
    input  win_ready, pe_valid, pe_data, pe_row, pe_col
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_PE = 2,
  parameter int PTR_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic [NUM_PE-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_PE-1:0] grant,
  output logic              any_grant
);

  logic found;

  assign any_grant = |req;

  // Walk the ring by offset k from ptr; the first requester hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PE; k++) begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % NUM_PE)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/window_dispatch.sv
// Round-robin dispatcher of line-buffer windows to NUM_PE conv engines.
// Tags each window with its output (row, col), counts fired windows and
// sequences the frame IDLE -> RUN -> DRAIN -> DONE.
module window_dispatch
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH   = 6,
  parameter int IMG_HEIGHT  = 6,
  parameter int CHANNELS    = 3,
  parameter int KERNEL_SIZE = 3,
  parameter int PADDING     = 1,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_PE      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  window_dispatch_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic [15:0]      win_count
);

  localparam int OUT_W = out_dim(IMG_WIDTH, PADDING, KERNEL_SIZE);
  localparam int OUT_H = out_dim(IMG_HEIGHT, PADDING, KERNEL_SIZE);
  localparam int WIN_W = win_width(DATA_WIDTH, KERNEL_SIZE, CHANNELS);
  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [7:0] LAST_COL = 8'(OUT_W - 1);
  localparam logic [7:0] LAST_ROW = 8'(OUT_H - 1);

  // Single output register: window, its tag and the engine it was granted to.
  typedef struct packed {
    logic              vld;
    logic [NUM_PE-1:0] grant;
    logic [7:0]        row;
    logic [7:0]        col;
    logic [WIN_W-1:0]  data;
  } slot_t;

  conv_state_e       state, state_nxt;
  slot_t             slot;
  logic [7:0]        row_cnt, col_cnt;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [NUM_PE-1:0] grant;
  logic              any_grant;
  logic              fire, accept, last_win, frame_start;

  rr_arbiter #(.NUM_PE(NUM_PE), .PTR_W(PTR_W)) u_arb (
    .req       (bus.pe_ready),
    .ptr       (rr_ptr),
    .grant     (grant),
    .any_grant (any_grant)
  );

  // Readiness is only looked at through the granted engine once the slot is full.
  assign fire        = slot.vld && |(slot.grant & bus.pe_ready);
  assign bus.win_ready = (state == RUN) && (!slot.vld || fire) && any_grant;
  assign accept      = bus.win_ready && bus.win_valid;
  assign last_win    = (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);
  assign frame_start = (state == IDLE) && start;

  assign bus.pe_valid = slot.vld ? slot.grant : '0;
  assign bus.pe_data  = slot.data;
  assign bus.pe_row   = slot.row;
  assign bus.pe_col   = slot.col;
  assign busy         = (state == RUN) || (state == DRAIN);
  assign done         = (state == DONE);

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frame sequencing; DRAIN ends on the cycle the last window leaves the slot.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_win) state_nxt = DRAIN;
      DRAIN:   if (!slot.vld || fire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer moves to just past the engine that won this accept.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    for (int i = 0; i < NUM_PE; i++) begin
      if (grant[i]) rr_ptr_nxt = PTR_W'((i + 1) % NUM_PE);
    end
  end

  // Round-robin pointer survives across frames; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr <= '0;
    else if (accept) rr_ptr <= rr_ptr_nxt;
  end

  // Output coordinate of the next window to be accepted, row-major.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (frame_start) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (accept) begin
      if (col_cnt == LAST_COL) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + 8'd1;
      end else begin
        col_cnt <= col_cnt + 8'd1;
      end
    end
  end

  // Output slot: load on accept (covers fire+accept), empty on a bare fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (accept) begin
      slot.vld   <= 1'b1;
      slot.grant <= grant;
      slot.row   <= row_cnt;
      slot.col   <= col_cnt;
      slot.data  <= bus.win_data;
    end else if (fire) begin
      slot.vld <= 1'b0;
    end
  end

  // Saturating count of windows handed to engines this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               win_count <= '0;
    else if (frame_start)                     win_count <= '0;
    else if (fire && win_count != 16'hFFFF)   win_count <= win_count + 16'd1;
  end

endmodule

// File: tb/tb_window_dispatch.sv
// Bench for window_dispatch: randomized frames against a transaction-level model.
`timescale 1ns/1ps
module tb_window_dispatch;

  localparam int NPE   = 2;
  localparam int OW    = 6 + 2 * 1 - 3 + 1;
  localparam int OH    = 6 + 2 * 1 - 3 + 1;
  localparam int TOTAL = OW * OH;
  localparam int WW    = 8 * 3 * 3 * 3;

  logic clk = 1'b0;
  logic rst_n, start, start2;
  logic busy, done, busy2, done2;
  logic [15:0] win_count, win_count2;

  int checks, errors;

  window_dispatch_if #(.WIN_W(WW), .NUM_PE(NPE)) bus ();
  window_dispatch_if #(.WIN_W(WW), .NUM_PE(NPE)) bus2 ();

  window_dispatch #(.IMG_WIDTH(6), .IMG_HEIGHT(6), .CHANNELS(3), .KERNEL_SIZE(3),
                    .PADDING(1), .DATA_WIDTH(8), .NUM_PE(NPE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .win_count(win_count));

  window_dispatch #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .CHANNELS(3), .KERNEL_SIZE(3),
                    .PADDING(0), .DATA_WIDTH(8), .NUM_PE(NPE)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2),
    .busy(busy2), .done(done2), .win_count(win_count2));

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 accepting, 2 waiting for last hand-off, 3 done.
  int m_phase, m_ptr, m_acc, m_cnt, m_sg, m_sr, m_sc;
  bit m_sv;
  logic [WW-1:0] m_sd;
  int fires, done_seen;
  int hits [NPE];

  function automatic logic [WW-1:0] rand_win();
    logic [WW-1:0] v;
    for (int b = 0; b < WW / 8; b++) v[b*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  function automatic bit m_fire();
    return m_sv && bus.pe_ready[m_sg];
  endfunction

  function automatic bit m_wr();
    return (m_phase == 1) && (!m_sv || m_fire()) && (bus.pe_ready != '0);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_acc = 0; m_cnt = 0;
    m_sv = 0; m_sg = 0; m_sr = 0; m_sc = 0; m_sd = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    bit f, a;
    int g;
    f = m_fire();
    a = m_wr() && bus.win_valid;
    if (f) begin
      if (m_cnt < 65535) m_cnt++;
      fires++;
      hits[m_sg]++;
    end
    case (m_phase)
      0: if (start) begin m_phase = 1; m_acc = 0; m_cnt = 0; end
      1: if (a && m_acc == TOTAL - 1) m_phase = 2;
      2: if (!m_sv || f) m_phase = 3;
      default: m_phase = 0;
    endcase
    if (f) m_sv = 0;
    if (a) begin
      g = -1;
      for (int k = 0; k < NPE; k++)
        if (g < 0 && bus.pe_ready[(m_ptr + k) % NPE]) g = (m_ptr + k) % NPE;
      m_sv = 1; m_sg = g; m_sd = bus.win_data;
      m_sr = m_acc / OW; m_sc = m_acc % OW;
      m_ptr = (g + 1) % NPE;
      m_acc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    bus.win_valid = 1'b1; bus.pe_ready = 2'b11; bus.win_data = rand_win();
    bus2.win_valid = 1'b0; bus2.pe_ready = 2'b00; bus2.win_data = '0;
    #3;
    checks += 8;
    if (bus.win_ready !== 1'b0) begin errors++; $display("FAIL reset win_ready: got %b want 0", bus.win_ready); end
    if (bus.pe_valid !== 2'b00) begin errors++; $display("FAIL reset pe_valid: got %b want 00", bus.pe_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    if (bus.pe_data !== '0) begin errors++; $display("FAIL reset pe_data: got %h want 0", bus.pe_data); end
    if (bus.pe_row !== 8'd0) begin errors++; $display("FAIL reset pe_row: got %0d want 0", bus.pe_row); end
    if (bus.pe_col !== 8'd0) begin errors++; $display("FAIL reset pe_col: got %0d want 0", bus.pe_col); end
    if (win_count !== 16'd0) begin errors++; $display("FAIL reset win_count: got %0d want 0", win_count); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ignore();
    start = 1'b0; bus.win_valid = 1'b1; bus.pe_ready = 2'b11;
    repeat (4) begin
      bus.win_data = rand_win();
      @(negedge clk);
      checks += 3;
      if (bus.win_ready !== 1'b0) begin errors++; $display("FAIL idle win_ready: got %b want 0", bus.win_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b want 0", busy); end
      if (bus.pe_valid !== 2'b00) begin errors++; $display("FAIL idle pe_valid: got %b want 00", bus.pe_valid); end
      @(posedge clk); model_step(); #1;
    end
  endtask

  // mode 0: all ready, 1: only PE1 ready, 2: random, 3: PE0 stall, 4: start re-pulsed in RUN
  task automatic test_frame(input string name, input int mode);
    int cyc, stall_left;
    bit stalled;
    logic [WW-1:0] hold;
    logic [NPE-1:0] exp_pv;
    fires = 0; done_seen = 0; hits = '{default: 0};
    cyc = 0; stall_left = 0; stalled = 0; hold = '0;
    do begin
      start = (cyc == 0) || (mode == 4 && cyc == 12);
      bus.win_data = rand_win();
      case (mode)
        1: begin bus.pe_ready = 2'b10; bus.win_valid = 1'b1; end
        2: begin bus.pe_ready = 2'($urandom_range(0, 3)); bus.win_valid = 1'($urandom_range(0, 1)); end
        3: begin
          bus.win_valid = 1'b1; bus.pe_ready = 2'b11;
          if (!stalled && m_sv && m_sg == 0 && m_acc >= 6) begin
            stalled = 1; stall_left = 5; hold = m_sd;
          end
          if (stall_left > 0) bus.pe_ready = 2'b10;
        end
        4: begin bus.pe_ready = 2'b11; bus.win_valid = 1'($urandom_range(0, 1)); end
        default: begin bus.pe_ready = 2'b11; bus.win_valid = 1'b1; end
      endcase
      @(negedge clk);
      exp_pv = m_sv ? NPE'(1 << m_sg) : '0;
      checks += 5;
      if (bus.win_ready !== m_wr()) begin errors++; $display("FAIL %s win_ready cyc %0d: got %b want %b", name, cyc, bus.win_ready, m_wr()); end
      if (bus.pe_valid !== exp_pv) begin errors++; $display("FAIL %s pe_valid cyc %0d: got %b want %b", name, cyc, bus.pe_valid, exp_pv); end
      if (busy !== (m_phase == 1 || m_phase == 2)) begin errors++; $display("FAIL %s busy cyc %0d: got %b want %b", name, cyc, busy, (m_phase == 1 || m_phase == 2)); end
      if (done !== (m_phase == 3)) begin errors++; $display("FAIL %s done cyc %0d: got %b want %b", name, cyc, done, (m_phase == 3)); end
      if (win_count !== 16'(m_cnt)) begin errors++; $display("FAIL %s win_count cyc %0d: got %0d want %0d", name, cyc, win_count, m_cnt); end
      if (exp_pv != '0) begin
        checks += 3;
        if (bus.pe_data !== m_sd) begin errors++; $display("FAIL %s pe_data cyc %0d: got %h want %h", name, cyc, bus.pe_data, m_sd); end
        if (bus.pe_row !== 8'(m_sr)) begin errors++; $display("FAIL %s pe_row cyc %0d: got %0d want %0d", name, cyc, bus.pe_row, m_sr); end
        if (bus.pe_col !== 8'(m_sc)) begin errors++; $display("FAIL %s pe_col cyc %0d: got %0d want %0d", name, cyc, bus.pe_col, m_sc); end
      end
      if (stall_left > 0) begin
        checks += 2;
        if (bus.win_ready !== 1'b0) begin errors++; $display("FAIL %s stall win_ready cyc %0d: got %b want 0", name, cyc, bus.win_ready); end
        if (bus.pe_data !== hold) begin errors++; $display("FAIL %s stall pe_data cyc %0d: got %h want %h", name, cyc, bus.pe_data, hold); end
        stall_left--;
      end
      if (done === 1'b1) done_seen++;
      @(posedge clk); model_step(); #1;
      cyc++;
    end while (m_phase != 0 && cyc < 2000);
    start = 1'b0;
    checks += 3;
    if (cyc >= 2000) begin errors++; $display("FAIL %s timeout: got %0d cycles want frame end", name, cyc); end
    if (fires != TOTAL) begin errors++; $display("FAIL %s fires: got %0d want %0d", name, fires, TOTAL); end
    if (done_seen != 1) begin errors++; $display("FAIL %s done pulses: got %0d want 1", name, done_seen); end
    checks++;
    if (win_count !== 16'(TOTAL)) begin errors++; $display("FAIL %s final win_count: got %0d want %0d", name, win_count, TOTAL); end
    if (mode == 0) begin
      checks++;
      if (hits[0] != TOTAL / 2 || hits[1] != TOTAL / 2) begin errors++; $display("FAIL %s split: got %0d/%0d want %0d/%0d", name, hits[0], hits[1], TOTAL / 2, TOTAL / 2); end
    end
    if (mode == 1) begin
      checks++;
      if (hits[0] != 0 || hits[1] != TOTAL) begin errors++; $display("FAIL %s split: got %0d/%0d want 0/%0d", name, hits[0], hits[1], TOTAL); end
    end
    if (mode == 3) begin
      checks++;
      if (!stalled) begin errors++; $display("FAIL %s stall occurred: got 0 want 1", name); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    cyc = 0;
    bus.pe_ready = 2'b11; bus.win_valid = 1'b1;
    while (m_acc < 10 && cyc < 100) begin
      start = (cyc == 0);
      bus.win_data = rand_win();
      @(posedge clk); model_step(); #1;
      cyc++;
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks += 7;
    if (bus.win_ready !== 1'b0) begin errors++; $display("FAIL midreset win_ready: got %b want 0", bus.win_ready); end
    if (bus.pe_valid !== 2'b00) begin errors++; $display("FAIL midreset pe_valid: got %b want 00", bus.pe_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b want 0", busy); end
    if (bus.pe_data !== '0) begin errors++; $display("FAIL midreset pe_data: got %h want 0", bus.pe_data); end
    if (bus.pe_row !== 8'd0) begin errors++; $display("FAIL midreset pe_row: got %0d want 0", bus.pe_row); end
    if (bus.pe_col !== 8'd0) begin errors++; $display("FAIL midreset pe_col: got %0d want 0", bus.pe_col); end
    if (win_count !== 16'd0) begin errors++; $display("FAIL midreset win_count: got %0d want 0", win_count); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_frame("after_reset", 0);
  endtask

  task automatic test_small();
    int tr[$], tc[$];
    int dn;
    dn = 0;
    bus2.win_valid = 1'b1; bus2.pe_ready = 2'b11; start2 = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus2.win_data = rand_win();
      @(negedge clk);
      if ((bus2.pe_valid & bus2.pe_ready) != '0) begin
        tr.push_back(int'(bus2.pe_row));
        tc.push_back(int'(bus2.pe_col));
      end
      if (done2 === 1'b1) dn++;
      @(posedge clk); #1;
      start2 = 1'b0;
    end
    checks += 4;
    if (tr.size() != 4) begin errors++; $display("FAIL small count: got %0d want 4", tr.size()); end
    if (dn != 1) begin errors++; $display("FAIL small done pulses: got %0d want 1", dn); end
    if (win_count2 !== 16'd4) begin errors++; $display("FAIL small win_count: got %0d want 4", win_count2); end
    if (busy2 !== 1'b0) begin errors++; $display("FAIL small busy: got %b want 0", busy2); end
    for (int i = 0; i < 4 && i < tr.size(); i++) begin
      checks++;
      if (tr[i] != i / 2 || tc[i] != i % 2) begin
        errors++;
        $display("FAIL small tag %0d: got (%0d,%0d) want (%0d,%0d)", i, tr[i], tc[i], i / 2, i % 2);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    model_reset();
    test_reset();
    test_idle_ignore();
    test_frame("alternate", 0);
    test_frame("pe1_only", 1);
    test_frame("stall_pe0", 3);
    test_frame("start_in_run", 4);
    test_frame("random", 2);
    test_reset_mid();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
